// File: rtl/tpu_pkg.sv
// tpu_pkg: drain FSM states, row-index width and flattened-tile indexing shared across the tile datapath
package tpu_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, STREAM} drain_state_e;
  function automatic int row_idx_w(input int size);
    return size > 1 ? $clog2(size) : 1;
  endfunction
  function automatic int elem_lsb(input int i, input int j, input int size, input int dw);
    return (i * size + j) * dw;
  endfunction
endpackage

// File: rtl/tile_row_mux.sv
// tile_row_mux: picks row `row` of flattened tile onto data when en, else zero (ports: tile, row, en -> data)
module tile_row_mux import tpu_pkg::*; #(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0] tile,
  input  logic [row_idx_w(SIZE)-1:0]      row,
  input  logic                            en,
  output logic [SIZE*DATA_WIDTH-1:0]      data
);
  localparam int ROW_W = SIZE * DATA_WIDTH;
  always_comb data = en ? tile[row*ROW_W +: ROW_W] : '0;
endmodule

// File: rtl/activation_drain.sv
// activation_drain: waits ACT_LATENCY, snapshots tile_in, streams rows over valid/ready (ports: clk rst start tile_in out_ready -> act_enable busy done out_valid out_data out_row out_last)
module activation_drain import tpu_pkg::*; #(
  parameter int SIZE        = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ACT_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0] tile_in,
  output logic                            act_enable,
  output logic                            busy,
  output logic                            done,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SIZE*DATA_WIDTH-1:0]      out_data,
  output logic [row_idx_w(SIZE)-1:0]      out_row,
  output logic                            out_last
);
  localparam int RW = row_idx_w(SIZE);
  drain_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic done_q, done_d;
  logic [SIZE*SIZE*DATA_WIDTH-1:0] buf_q, buf_d;
  logic capture, fire, last;
  always_comb begin
    capture = state_q == WAIT && cnt_q == 4'd0;
    last    = row_q == RW'(SIZE - 1);
    fire    = state_q == STREAM && out_ready;
    state_d = state_q == IDLE ? (start ? WAIT : IDLE)
            : state_q == WAIT ? (capture ? STREAM : WAIT)
            : (fire && last ? IDLE : STREAM);
    cnt_d   = state_q == IDLE && start ? 4'(ACT_LATENCY)
            : state_q == WAIT && !capture ? cnt_q - 4'd1 : cnt_q;
    row_d   = capture ? '0 : fire ? row_q + 1'b1 : row_q;
    done_d  = fire && last;
    buf_d   = capture ? tile_in : buf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end
  always_ff @(posedge clk) buf_q <= buf_d;
  assign act_enable = state_q == WAIT;
  assign busy       = state_q != IDLE;
  assign out_valid  = state_q == STREAM;
  assign out_row    = row_q;
  assign out_last   = out_valid && last;
  assign done       = done_q;
  tile_row_mux #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH)) u_mux (
    .tile(buf_q),
    .row (row_q),
    .en  (out_valid),
    .data(out_data)
  );
endmodule

// File: tb/tb_activation_drain.sv
// tb_activation_drain: randomized self-checking bench for activation_drain against a row-queue reference model
module tb_activation_drain;
  logic clk, rst, start, start0, out_ready;
  logic [1023:0] tile_in;
  logic act_enable, busy, done, out_valid, out_last;
  logic [127:0] out_data;
  logic [2:0] out_row;
  logic act_enable0, busy0, done0, out_valid0, out_last0;
  logic [127:0] out_data0;
  logic [2:0] out_row0;
  logic [15:0] ref_t [8][8];
  int checks = 0;
  int passes = 0;

  activation_drain #(.SIZE(8), .DATA_WIDTH(16), .ACT_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .start(start), .tile_in(tile_in), .act_enable(act_enable),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_last(out_last)
  );
  activation_drain #(.SIZE(8), .DATA_WIDTH(16), .ACT_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .tile_in(tile_in), .act_enable(act_enable0),
    .busy(busy0), .done(done0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_row(out_row0), .out_last(out_last0)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_tile(input bit rnd);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        ref_t[i][j] = rnd ? 16'($urandom) : 16'(256 * i + j);
        tile_in[(i*8+j)*16 +: 16] = ref_t[i][j];
      end
  endtask

  function automatic logic [127:0] exp_row(input int r);
    logic [127:0] v;
    for (int j = 0; j < 8; j++) v[j*16 +: 16] = ref_t[r][j];
    return v;
  endfunction

  task automatic test_reset;
    rst = 1; start = 0; start0 = 0; out_ready = 1; tile_in = '0;
    step; step;
    rst = 0;
    checks++; if ({act_enable, busy, done, out_valid, out_last} !== 5'b0) $display("FAIL reset_ctrl: got %b required 00000", {act_enable, busy, done, out_valid, out_last}); else passes++;
    checks++; if (out_row !== 3'd0 || out_data !== '0) $display("FAIL reset_data: got row %0d data %h required 0/0", out_row, out_data); else passes++;
    checks++; if ({act_enable0, busy0, done0, out_valid0, out_last0, out_row0} !== 8'b0 || out_data0 !== '0) $display("FAIL reset_dut0: got %b required 0", {act_enable0, busy0, done0, out_valid0}); else passes++;
    step;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL reset_idle: got busy %b valid %b required 0 0", busy, out_valid); else passes++;
  endtask

  task automatic test_basic;
    set_tile(0);
    start = 1; step; start = 0;
    checks++; if ({act_enable, busy, out_valid} !== 3'b110) $display("FAIL basic_wait1: got %b required 110", {act_enable, busy, out_valid}); else passes++;
    step;
    checks++; if ({act_enable, busy, out_valid} !== 3'b110) $display("FAIL basic_wait2: got %b required 110", {act_enable, busy, out_valid}); else passes++;
    step;
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (out_valid !== 1'b1 || act_enable !== 1'b0 || out_row !== 3'(r) || out_last !== (r == 7) || out_data !== exp_row(r))
        $display("FAIL basic_row%0d: got v%b row %0d last %b data %h required v1 row %0d last %b data %h", r, out_valid, out_row, out_last, out_data, r, r == 7, exp_row(r));
      else passes++;
      if (r == 3) begin
        checks++; if (out_data[80 +: 16] !== 16'h0305) $display("FAIL basic_elem35: got %h required 0305", out_data[80 +: 16]); else passes++;
      end
      step;
    end
    checks++; if ({done, busy, out_valid, out_last} !== 4'b1000) $display("FAIL basic_done: got %b required 1000", {done, busy, out_valid, out_last}); else passes++;
    step;
    checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b required 0", done); else passes++;
  endtask

  task automatic test_random_stream;
    int lat, k, n;
    for (int it = 0; it < 4; it++) begin
      set_tile(1);
      start = 1; step; start = 0;
      lat = 1;
      while (!out_valid && lat < 20) begin step; lat++; end
      checks++; if (lat !== 3) $display("FAIL rand_latency: got %0d required 3", lat); else passes++;
      k = 0; n = 0;
      while (k < 8 && n < 200) begin
        checks++;
        if (out_valid !== 1'b1 || out_row !== 3'(k) || out_last !== (k == 7) || out_data !== exp_row(k))
          $display("FAIL rand_beat: got v%b row %0d data %h required v1 row %0d data %h", out_valid, out_row, out_data, k, exp_row(k));
        else passes++;
        out_ready = 1'($urandom_range(0, 1));
        if (out_ready) k++;
        step; n++;
      end
      out_ready = 1;
      checks++; if (k !== 8 || done !== 1'b1 || busy !== 1'b0) $display("FAIL rand_done: got rows %0d done %b busy %b required 8 1 0", k, done, busy); else passes++;
      step;
    end
  endtask

  task automatic test_backpressure;
    int k, n, stalls, held;
    set_tile(1);
    start = 1; step; start = 0;
    n = 0;
    while (!out_valid && n < 20) begin step; n++; end
    k = 0; n = 0; stalls = 0; held = 0;
    while (k < 8 && n < 40) begin
      if (out_row === 3'd2) held++;
      checks++;
      if (out_valid !== 1'b1 || out_row !== 3'(k) || out_data !== exp_row(k))
        $display("FAIL bp_beat: got v%b row %0d data %h required v1 row %0d data %h", out_valid, out_row, out_data, k, exp_row(k));
      else passes++;
      out_ready = !(k == 2 && stalls < 3);
      if (out_ready) k++; else stalls++;
      step; n++;
    end
    out_ready = 1;
    checks++; if (n !== 11 || held !== 4) $display("FAIL bp_span: got span %0d row2 cycles %0d required 11 4", n, held); else passes++;
    checks++; if (done !== 1'b1) $display("FAIL bp_done: got %b required 1", done); else passes++;
    step;
  endtask

  task automatic test_snapshot;
    set_tile(1);
    start = 1; step; start = 0; step; step;
    tile_in = {1024{1'b1}};
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row !== 3'(r) || out_data !== exp_row(r))
        $display("FAIL snap_row%0d: got v%b row %0d data %h required %h", r, out_valid, out_row, out_data, exp_row(r));
      else passes++;
      step;
    end
    checks++; if (done !== 1'b1) $display("FAIL snap_done: got %b required 1", done); else passes++;
    step;
  endtask

  task automatic test_ignored_start;
    int k, ndone, extra;
    bit seen;
    set_tile(1);
    start = 1; step; start = 0;
    k = 0; ndone = 0; extra = 0; seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (seen && busy) extra++;
      if (done) begin ndone++; seen = 1; end
      if (out_valid) begin
        checks++;
        if (out_row !== 3'(k) || out_data !== exp_row(k)) $display("FAIL ign_beat: got row %0d data %h required row %0d data %h", out_row, out_data, k, exp_row(k));
        else passes++;
        k++;
      end
      start = out_valid && out_row == 3'd4;
      step;
    end
    start = 0;
    checks++; if (k !== 8 || ndone !== 1 || extra !== 0) $display("FAIL ign_summary: got rows %0d dones %0d busy-after %0d required 8 1 0", k, ndone, extra); else passes++;
  endtask

  task automatic test_reset_mid;
    int n, ndone;
    set_tile(1);
    start = 1; step; start = 0;
    n = 0;
    while (!(out_valid && out_row == 3'd5) && n < 30) begin step; n++; end
    checks++; if (out_row !== 3'd5) $display("FAIL rst_reach_row5: got %0d required 5", out_row); else passes++;
    rst = 1; step; rst = 0;
    checks++; if ({out_valid, busy, done, act_enable, out_last} !== 5'b0 || out_row !== 3'd0 || out_data !== '0) $display("FAIL rst_mid: got %b row %0d required 00000 row 0", {out_valid, busy, done, act_enable, out_last}, out_row); else passes++;
    ndone = 0;
    for (int c = 0; c < 4; c++) begin ndone += int'(done) + int'(busy); step; end
    checks++; if (ndone !== 0) $display("FAIL rst_quiet: got %0d activity cycles required 0", ndone); else passes++;
    set_tile(1);
    start = 1; step; start = 0; step; step;
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (out_valid !== 1'b1 || out_row !== 3'(r) || out_data !== exp_row(r)) $display("FAIL rst_redrain_row%0d: got v%b row %0d data %h required %h", r, out_valid, out_row, out_data, exp_row(r));
      else passes++;
      step;
    end
    checks++; if (done !== 1'b1) $display("FAIL rst_redrain_done: got %b required 1", done); else passes++;
    step;
  endtask

  task automatic test_zero_latency;
    set_tile(1);
    start0 = 1; step; start0 = 0;
    checks++; if ({act_enable0, busy0, out_valid0} !== 3'b110) $display("FAIL zl_wait: got %b required 110", {act_enable0, busy0, out_valid0}); else passes++;
    step;
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 8; r++) begin
        checks++;
        if (out_valid0 !== 1'b1 || out_row0 !== 3'(r) || out_last0 !== (r == 7) || out_data0 !== exp_row(r))
          $display("FAIL zl_row%0d_drain%0d: got v%b row %0d data %h required row %0d data %h", r, d, out_valid0, out_row0, out_data0, r, exp_row(r));
        else passes++;
        step;
      end
      checks++; if ({done0, busy0} !== 2'b10) $display("FAIL zl_done%0d: got %b required 10", d, {done0, busy0}); else passes++;
      if (d == 0) begin
        start0 = 1; step; start0 = 0;
        checks++; if ({act_enable0, busy0, done0, out_valid0} !== 4'b1100) $display("FAIL zl_b2b_wait: got %b required 1100", {act_enable0, busy0, done0, out_valid0}); else passes++;
        step;
      end
    end
    step;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_random_stream;
    test_backpressure;
    test_snapshot;
    test_ignored_start;
    test_reset_mid;
    test_zero_latency;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
